ifetch_unit: RTL and testbench

//  Instruction-fetch stage that drives the IF/ID pipeline register: generates the fetch PC,

---
 rtl/ifetch_unit.sv | 90 +++++++++
 tb/tb_ifetch_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch PC generation, imem request/grant/response handshake, fetch buffer
// feeding IF/ID, with stall handling and redirect-time discard of in-flight fetches.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_le_o,
  output logic        ifid_flush_o
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] cnt_q, cnt_d, infl_q, infl_d, kill_q, kill_d;
  logic [AW-1:0] brd_q, brd_d, bwr_q, bwr_d, ard_q, ard_d, awr_q, awr_d;
  logic [31:0]   instr_q [BUF_DEPTH];
  logic [31:0]   pc4_q   [BUF_DEPTH];
  logic [31:0]   addr_q  [BUF_DEPTH];
  logic [CW+1:0] used;
  logic          gnt, rsp_kill, rsp_live, push, pop;
  // Killed fetches still hold address-queue slots until their responses drain.
  always_comb begin
    used         = {2'b0, cnt_q} + {2'b0, infl_q} + {2'b0, kill_q};
    imem_req_o   = rst_n & (used < (CW+2)'(BUF_DEPTH)) & ~br_taken_i;
    imem_addr_o  = fpc_q;
    gnt          = imem_req_o & imem_gnt_i;
    rsp_kill     = imem_rvalid_i & (kill_q != '0);
    rsp_live     = imem_rvalid_i & (kill_q == '0) & (infl_q != '0);
    ifid_le_o    = rst_n & ~br_taken_i & ~stall_i & (cnt_q != '0);
    ifid_flush_o = rst_n & (br_taken_i | (~stall_i & (cnt_q == '0)));
    ifid_instr_o = (cnt_q != '0) ? instr_q[brd_q] : '0;
    ifid_pc4_o   = (cnt_q != '0) ? pc4_q[brd_q] : '0;
    push         = rsp_live & ~br_taken_i;
    pop          = ifid_le_o;
    fpc_d        = br_taken_i ? (br_target_i & ~32'd3) : gnt ? fpc_q + 32'd4 : fpc_q;
    cnt_d        = br_taken_i ? '0 : cnt_q + CW'(push) - CW'(pop);
    brd_d        = br_taken_i ? '0 : brd_q + AW'(pop);
    bwr_d        = br_taken_i ? '0 : bwr_q + AW'(push);
    infl_d       = br_taken_i ? '0 : infl_q + CW'(gnt) - CW'(rsp_live);
    kill_d       = br_taken_i ? kill_q + infl_q - CW'(rsp_kill) - CW'(rsp_live)
                              : kill_q - CW'(rsp_kill);
    ard_d        = ard_q + AW'(rsp_kill | rsp_live);
    awr_d        = awr_q + AW'(gnt);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q  <= RESET_PC;
      cnt_q  <= '0;
      infl_q <= '0;
      kill_q <= '0;
      brd_q  <= '0;
      bwr_q  <= '0;
      ard_q  <= '0;
      awr_q  <= '0;
    end else begin
      fpc_q  <= fpc_d;
      cnt_q  <= cnt_d;
      infl_q <= infl_d;
      kill_q <= kill_d;
      brd_q  <= brd_d;
      bwr_q  <= bwr_d;
      ard_q  <= ard_d;
      awr_q  <= awr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[bwr_q] <= imem_rdata_i;
      pc4_q[bwr_q]   <= addr_q[ard_q] + 32'd4;
    end
    if (gnt) addr_q[awr_q] <= fpc_q;
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (used <= (CW+2)'(BUF_DEPTH));
      assert (!(push && !pop && cnt_q == CW'(BUF_DEPTH)));
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed table, corner sequences and random traffic checked against a
// queue-based fetch model plus a responding instruction memory.
module tb_ifetch_unit;
  localparam int D = 2;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req, gnt, rvalid, stall, br, le, flush;
  logic [31:0] addr, rdata, target, instr, pc4;
  always #5 clk = ~clk;
  ifetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .stall_i(stall), .br_taken_i(br),
    .br_target_i(target), .ifid_instr_o(instr), .ifid_pc4_o(pc4), .ifid_le_o(le),
    .ifid_flush_o(flush)
  );
  int errs = 0, checks = 0;
  typedef struct {logic [31:0] pc; bit dead;} pend_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc4;} ent_t;
  typedef struct {bit rv; logic req; logic [31:0] addr; logic le; logic flush;
                  logic [31:0] instr; logic [31:0] pc4;} vec_t;
  pend_t       pend[$];
  ent_t        fb[$];
  logic [31:0] memq[$];
  logic [31:0] fpc;
  bit          m_req, m_le;
  logic        s_req, s_le, s_flush;
  logic [31:0] s_addr, s_instr, s_pc4;
  vec_t        tv[6];
  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic model_chk();
    m_req = (pend.size() + fb.size() < D) && !br;
    m_le  = !br && !stall && fb.size() > 0;
    chk("m_req", req, m_req);
    chk("m_addr", addr, fpc);
    chk("m_le", le, m_le);
    chk("m_flush", flush, br || (!stall && fb.size() == 0));
    chk("m_instr", instr, fb.size() > 0 ? fb[0].instr : 32'h0);
    chk("m_pc4", pc4, fb.size() > 0 ? fb[0].pc4 : 32'h0);
  endtask
  task automatic model_step();
    pend_t e;
    if (m_le) fb.delete(0);
    if (rvalid && pend.size() > 0) begin
      e = pend.pop_front();
      if (!e.dead && !br) fb.push_back('{memf(e.pc), e.pc + 32'd4});
    end
    if (br) begin
      fb.delete();
      foreach (pend[i]) pend[i].dead = 1'b1;
      fpc = target & ~32'd3;
    end else if (m_req && gnt) begin
      pend.push_back('{fpc, 1'b0});
      fpc = fpc + 32'd4;
    end
  endtask
  task automatic cycle(input bit s, input bit b, input bit g, input bit rv, input logic [31:0] t);
    @(negedge clk);
    stall = s; br = b; gnt = g; target = t; rvalid = rv; rdata = 32'hDEAD_BEEF;
    if (rv && memq.size() > 0) rdata = memf(memq.pop_front());
    #1;
    s_req = req; s_le = le; s_flush = flush; s_addr = addr; s_instr = instr; s_pc4 = pc4;
    model_chk();
    if (req && gnt) memq.push_back(addr);
    @(posedge clk);
    model_step();
  endtask
  task automatic do_reset(input bit keep_mem);
    @(negedge clk);
    rst_n = 1'b0; stall = 0; br = 0; gnt = 1; rvalid = 0; rdata = 0; target = 32'h40;
    #1;
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_le", le, 0);
    chk("rst_flush", flush, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc4", pc4, 0);
    gnt = 0;
    pend.delete(); fb.delete(); fpc = 32'h0;
    if (!keep_mem) memq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic run_until_le(input string name);
    for (int i = 0; i < 20 && !s_le; i++) cycle(0, 0, 1, memq.size() > 0, 0);
    chk(name, s_le, 1);
  endtask
  initial begin
    stall = 0; br = 0; gnt = 0; rvalid = 0; rdata = 0; target = 0;
    tv[0] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b1, 32'h0,         32'h0};
    tv[1] = '{1'b1, 1'b1, 32'h4,  1'b0, 1'b1, 32'h0,         32'h0};
    tv[2] = '{1'b1, 1'b0, 32'h8,  1'b1, 1'b0, 32'hA000_0000, 32'h4};
    tv[3] = '{1'b0, 1'b1, 32'h8,  1'b1, 1'b0, 32'hA000_0004, 32'h8};
    tv[4] = '{1'b1, 1'b1, 32'hC,  1'b0, 1'b1, 32'h0,         32'h0};
    tv[5] = '{1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 32'hA000_0008, 32'hC};
    do_reset(0);
    foreach (tv[i]) begin
      cycle(0, 0, 1, tv[i].rv, 0);
      chk($sformatf("t1_req%0d", i), s_req, tv[i].req);
      chk($sformatf("t1_addr%0d", i), s_addr, tv[i].addr);
      chk($sformatf("t1_le%0d", i), s_le, tv[i].le);
      chk($sformatf("t1_flush%0d", i), s_flush, tv[i].flush);
      chk($sformatf("t1_instr%0d", i), s_instr, tv[i].instr);
      chk($sformatf("t1_pc4%0d", i), s_pc4, tv[i].pc4);
    end
    do_reset(0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 1, memq.size() > 0, 0);
      chk("t2_le", s_le, 0);
      chk("t2_flush", s_flush, 0);
    end
    chk("t2_req", s_req, 0);
    cycle(0, 0, 1, memq.size() > 0, 0);
    chk("t2_le0", s_le, 1);
    chk("t2_instr0", s_instr, memf(32'h0));
    chk("t2_pc40", s_pc4, 32'h4);
    cycle(0, 0, 1, memq.size() > 0, 0);
    chk("t2_le1", s_le, 1);
    chk("t2_instr1", s_instr, memf(32'h4));
    chk("t2_pc41", s_pc4, 32'h8);
    do_reset(0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk("t3_req", s_req, 1);
      chk("t3_addr", s_addr, 32'h0);
    end
    cycle(0, 0, 1, 0, 0);
    chk("t3_gaddr", s_addr, 32'h0);
    cycle(0, 0, 0, 0, 0);
    chk("t3_fpc", s_addr, 32'h4);
    do_reset(0);
    cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0);
    chk("t4_addr", s_addr, 32'hC);
    cycle(0, 1, 1, 0, 32'h103);
    chk("t4_flush", s_flush, 1);
    chk("t4_req", s_req, 0);
    run_until_le("t4_le");
    chk("t4_instr", s_instr, memf(32'h100));
    chk("t4_pc4", s_pc4, 32'h104);
    do_reset(0);
    cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 1, 0);
    cycle(1, 1, 1, 1, 32'h200);
    chk("t5_flush", s_flush, 1);
    chk("t5_le", s_le, 0);
    chk("t5_req", s_req, 0);
    run_until_le("t5_dle");
    chk("t5_instr", s_instr, memf(32'h200));
    chk("t5_pc4", s_pc4, 32'h204);
    do_reset(0);
    cycle(0, 0, 1, 0, 0); cycle(0, 0, 1, 0, 0);
    do_reset(1);
    cycle(0, 0, 0, 1, 0); cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    chk("t6_req", s_req, 1);
    chk("t6_addr", s_addr, 32'h0);
    chk("t6_flush", s_flush, 1);
    run_until_le("t6_le");
    chk("t6_instr", s_instr, memf(32'h0));
    chk("t6_pc4", s_pc4, 32'h4);
    do_reset(0);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
            memq.size() > 0 && $urandom_range(0, 2) != 0, $urandom);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
